// File: rtl/valve_pkg.sv
// Shared definitions for the latching-solenoid valve driver.
//   state_e       : FSM state encoding (one code per valve sequence phase)
//   Def*          : default timing constants in clk_i cycles
//   state_busy()  : true for the dead-time and pulse phases
package valve_pkg;

    typedef enum logic [2:0] {
        StClosed  = 3'd0,
        StDeadO   = 3'd1,
        StPulseO  = 3'd2,
        StOpened  = 3'd3,
        StDeadC   = 3'd4,
        StPulseC  = 3'd5,
        StLockout = 3'd6,
        StFault   = 3'd7
    } state_e;

    localparam int unsigned DefCntW         = 16;
    localparam int unsigned DefDeadCycles   = 4;
    localparam int unsigned DefPulseCycles  = 50;
    localparam int unsigned DefMinOffCycles = 200;
    localparam int unsigned DefMaxOnCycles  = 60000;

    // A sequence is "in progress" whenever the H-bridge is either settling or driving.
    function automatic logic state_busy(input state_e s);
        return (s == StDeadO) || (s == StPulseO) || (s == StDeadC) || (s == StPulseC);
    endfunction

endpackage

// File: rtl/valve_timer.sv
// Loadable saturating down-counter used for phase timing and the on-time watchdog.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load value_i this cycle (wins over en_i)
//   en_i          : count down by one while nonzero
//   value_i       : load value
//   done_o        : counter currently holds 1 (last cycle of the loaded interval)
module valve_timer #(
    parameter int unsigned CntW     = 16,
    parameter int unsigned ResetVal = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [CntW-1:0] value_i,
    output logic            done_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Stops at zero, so a zero load never produces done_o and never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= CntW'(ResetVal);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/valve_driver.sv
// H-bridge back-end for a latching solenoid valve.
// Turns the level watering request into timed open/close pulses with break-before-make
// dead time, a post-close lockout and a maximum-on watchdog.
//   clk_i, rst_ni  : clock, asynchronous active-low reset (release expected synchronous)
//   water_req_i    : 1 = valve should be open
//   fault_clr_i    : single-cycle pulse clearing a latched watchdog fault
//   drive_open_o   : H-bridge open-direction drive
//   drive_close_o  : H-bridge close-direction drive
//   valve_open_o   : valve believed open
//   busy_o         : dead-time or pulse sequence in progress
//   fault_o        : watchdog tripped, latched until fault_clr_i in the fault state
module valve_driver
    import valve_pkg::*;
#(
    parameter int unsigned CntW         = DefCntW,
    parameter int unsigned DeadCycles   = DefDeadCycles,   // >= 1
    parameter int unsigned PulseCycles  = DefPulseCycles,  // >= 1
    parameter int unsigned MinOffCycles = DefMinOffCycles, // 0 = no lockout
    parameter int unsigned MaxOnCycles  = DefMaxOnCycles   // 0 = watchdog off
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic water_req_i,
    input  logic fault_clr_i,
    output logic drive_open_o,
    output logic drive_close_o,
    output logic valve_open_o,
    output logic busy_o,
    output logic fault_o
);

    localparam bit NoLockout = (MinOffCycles == 0);

    state_e state_q, state_d;
    logic   fault_q, fault_d;
    logic   drive_open_q, drive_close_q, valve_open_q, busy_q;

    logic            st_load, st_done;
    logic [CntW-1:0] st_value;
    logic            wd_load, wd_en, wd_done;

    // Phase timer: reloaded on every state change, so each timed state lasts exactly
    // its programmed number of cycles. Reset state is DEAD_C, hence the reset value.
    valve_timer #(
        .CntW     (CntW),
        .ResetVal (DeadCycles)
    ) u_state_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (st_load),
        .en_i    (1'b1),
        .value_i (st_value),
        .done_o  (st_done)
    );

    // Watchdog: loaded on entry to OPENED and only counts while there.
    valve_timer #(
        .CntW     (CntW),
        .ResetVal (0)
    ) u_on_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (wd_load),
        .en_i    (wd_en),
        .value_i (CntW'(MaxOnCycles)),
        .done_o  (wd_done)
    );

    // Next state. water_req_i is only looked at in CLOSED and OPENED, so a pulse that
    // has started always runs to completion.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        unique case (state_q)
            StClosed: begin
                if (water_req_i) state_d = StDeadO;
            end
            StDeadO: begin
                if (st_done) state_d = StPulseO;
            end
            StPulseO: begin
                if (st_done) state_d = StOpened;
            end
            StOpened: begin
                // Watchdog wins over a simultaneous request drop.
                if (wd_done) begin
                    fault_d = 1'b1;
                    state_d = StDeadC;
                end else if (!water_req_i) begin
                    state_d = StDeadC;
                end
            end
            StDeadC: begin
                if (st_done) state_d = StPulseC;
            end
            StPulseC: begin
                if (st_done) begin
                    if (fault_q)        state_d = StFault;
                    else if (NoLockout) state_d = StClosed;
                    else                state_d = StLockout;
                end
            end
            StLockout: begin
                if (st_done) state_d = StClosed;
            end
            StFault: begin
                if (fault_clr_i) begin
                    fault_d = 1'b0;
                    state_d = NoLockout ? StClosed : StLockout;
                end
            end
            default: begin
                state_d = StDeadC;
            end
        endcase
    end

    // Timer control derived from the upcoming state.
    always_comb begin
        st_load  = (state_d != state_q);
        st_value = '0;
        unique case (state_d)
            StDeadO, StDeadC:   st_value = CntW'(DeadCycles);
            StPulseO, StPulseC: st_value = CntW'(PulseCycles);
            StLockout:          st_value = CntW'(MinOffCycles);
            default:            st_value = '0;
        endcase
        wd_load = (state_d == StOpened) && (state_q != StOpened);
        wd_en   = (state_q == StOpened);
    end

    // Outputs are decoded from the next state and registered, so they change on the
    // same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StDeadC;
            fault_q       <= 1'b0;
            drive_open_q  <= 1'b0;
            drive_close_q <= 1'b0;
            valve_open_q  <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            fault_q       <= fault_d;
            drive_open_q  <= (state_d == StPulseO);
            drive_close_q <= (state_d == StPulseC);
            valve_open_q  <= (state_d == StOpened);
            busy_q        <= state_busy(state_d);
        end
    end

    assign drive_open_o  = drive_open_q;
    assign drive_close_o = drive_close_q;
    assign valve_open_o  = valve_open_q;
    assign busy_o        = busy_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_valve_driver.sv
// Directed bench for valve_driver (DEAD=4, PULSE=50, MIN_OFF=200, MAX_ON=1000).
// Outputs are sampled 1 time unit after each rising edge as {open, close, vopen, busy, fault}.
module tb_valve_driver;

    logic clk = 1'b0;
    logic rst_n;
    logic water_req;
    logic fault_clr;
    logic drive_open, drive_close, valve_open, busy, fault;
    logic [4:0] outs;

    int n_chk = 0;
    int n_err = 0;

    assign outs = {drive_open, drive_close, valve_open, busy, fault};

    always #5 clk = ~clk;

    valve_driver #(
        .CntW         (16),
        .DeadCycles   (4),
        .PulseCycles  (50),
        .MinOffCycles (200),
        .MaxOnCycles  (1000)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .water_req_i   (water_req),
        .fault_clr_i   (fault_clr),
        .drive_open_o  (drive_open),
        .drive_close_o (drive_close),
        .valve_open_o  (valve_open),
        .busy_o        (busy),
        .fault_o       (fault)
    );

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n consecutive post-edge samples must all equal exp.
    task automatic expect_seq(input string tag, input int n, input logic [4:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq($sformatf("%s[%0d]", tag, i), outs, exp);
        end
    endtask

    localparam logic [4:0] Idle   = 5'b00000;
    localparam logic [4:0] Dead   = 5'b00010;
    localparam logic [4:0] POpen  = 5'b10010;
    localparam logic [4:0] Opened = 5'b00100;
    localparam logic [4:0] PClose = 5'b01010;
    localparam logic [4:0] DeadF  = 5'b00011;
    localparam logic [4:0] PCloF  = 5'b01011;
    localparam logic [4:0] Fault  = 5'b00001;

    initial begin
        rst_n     = 1'b1;
        water_req = 1'b0;
        fault_clr = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_eq("reset_state", outs, Dead);
        tick();
        tick();
        check_eq("reset_held", outs, Dead);
        rst_n = 1'b1;

        // Power-up close sequence, then lockout with req toggled inside it.
        expect_seq("init_dead", 3, Dead);
        expect_seq("init_close", 50, PClose);
        expect_seq("lock_a", 10, Idle);
        water_req = 1'b1;
        expect_seq("lock_req_hi", 50, Idle);
        water_req = 1'b0;
        expect_seq("lock_req_lo", 150, Idle);

        // Normal open and close.
        water_req = 1'b1;
        expect_seq("open_dead", 4, Dead);
        expect_seq("open_pulse", 50, POpen);
        expect_seq("opened", 20, Opened);
        water_req = 1'b0;
        expect_seq("close_dead", 4, Dead);
        expect_seq("close_pulse", 50, PClose);
        expect_seq("lock_b", 205, Idle);

        // Request dropped 10 cycles into the open pulse.
        water_req = 1'b1;
        expect_seq("short_dead", 4, Dead);
        expect_seq("short_pulse_a", 10, POpen);
        water_req = 1'b0;
        expect_seq("short_pulse_b", 40, POpen);
        expect_seq("short_opened", 1, Opened);
        expect_seq("short_cdead", 4, Dead);
        expect_seq("short_close", 50, PClose);
        expect_seq("lock_c", 205, Idle);

        // Watchdog trip with req held high; fault_clr ignored outside FAULT.
        water_req = 1'b1;
        expect_seq("wd_dead", 4, Dead);
        expect_seq("wd_pulse", 50, POpen);
        expect_seq("wd_opened", 1000, Opened);
        expect_seq("wd_cdead", 4, DeadF);
        expect_seq("wd_close_a", 20, PCloF);
        fault_clr = 1'b1;
        expect_seq("wd_clr_ignored", 1, PCloF);
        fault_clr = 1'b0;
        expect_seq("wd_close_b", 29, PCloF);
        expect_seq("wd_fault_hold", 30, Fault);
        fault_clr = 1'b1;
        expect_seq("wd_fault_clr", 1, Idle);
        fault_clr = 1'b0;
        expect_seq("wd_lock", 200, Idle);
        expect_seq("reopen_dead", 4, Dead);
        expect_seq("reopen_pulse", 10, POpen);

        // Reset in the middle of the open pulse.
        rst_n = 1'b0;
        #1 check_eq("rst_async", outs, Dead);
        water_req = 1'b0;
        tick();
        check_eq("rst_hold", outs, Dead);
        rst_n = 1'b1;
        expect_seq("rst_dead", 3, Dead);
        expect_seq("rst_close", 50, PClose);
        expect_seq("rst_lock", 10, Idle);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
